// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder over GF(16), p(x) = x^4 + x + 1.
// Eleven serial data symbols are forwarded unchanged while a remainder LFSR
// divides by g(x) = x^4 + D x^3 + C x^2 + 8 x + 7; the four remainder symbols
// (highest order first) then follow back to back as parity.
//
// Handshake: a data symbol is accepted on a rising edge where
// IN_VALID && IN_READY. IN_READY depends only on the state (high in DATA).
// The output side has no backpressure. Each emitted symbol shows up on OUT_*
// for exactly one cycle with OUT_VALID=1, and OUT_VALID is 0 in idle cycles.
module rs_encoder_15_11 (
  input  logic       CLK,
  input  logic       RESET_GLOBAL,
  input  logic [3:0] IN_SERIAL,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [3:0] OUT_SERIAL,
  output logic       OUT_VALID,
  output logic       OUT_PARITY,
  output logic       OUT_LAST
);

  typedef enum logic {ST_DATA = 1'b0, ST_PARITY = 1'b1} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] r0, r1, r2, r3;
  logic [3:0] r0_n, r1_n, r2_n, r3_n;
  logic [3:0] out_serial_n;
  logic       out_valid_n, out_parity_n, out_last_n;
  logic [3:0] fb;

  // GF(16) multiply mod x^4+x+1; with a constant operand it folds to XORs.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  assign IN_READY = (state == ST_DATA);
  assign fb       = IN_SERIAL ^ r3;

  // Next-state, LFSR and output computation; idle cycles emit nothing.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    r0_n         = r0;
    r1_n         = r1;
    r2_n         = r2;
    r3_n         = r3;
    out_serial_n = 4'h0;
    out_valid_n  = 1'b0;
    out_parity_n = 1'b0;
    out_last_n   = 1'b0;
    case (state)
      ST_DATA: begin
        if (IN_VALID) begin
          r3_n         = r2 ^ gf_mul(fb, 4'hD);
          r2_n         = r1 ^ gf_mul(fb, 4'hC);
          r1_n         = r0 ^ gf_mul(fb, 4'h8);
          r0_n         = gf_mul(fb, 4'h7);
          out_serial_n = IN_SERIAL;
          out_valid_n  = 1'b1;
          if (cnt == 4'd10) begin
            cnt_n   = 4'd0;
            state_n = ST_PARITY;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        out_serial_n = r3;
        out_valid_n  = 1'b1;
        out_parity_n = 1'b1;
        r3_n         = r2;
        r2_n         = r1;
        r1_n         = r0;
        r0_n         = 4'h0;
        if (cnt == 4'd3) begin
          out_last_n = 1'b1;
          r3_n       = 4'h0;
          r2_n       = 4'h0;
          r1_n       = 4'h0;
          cnt_n      = 4'd0;
          state_n    = ST_DATA;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = ST_DATA;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // State, remainder and registered outputs; reset aborts any codeword.
  always_ff @(posedge CLK) begin
    if (RESET_GLOBAL) begin
      state      <= ST_DATA;
      cnt        <= 4'd0;
      r0         <= 4'h0;
      r1         <= 4'h0;
      r2         <= 4'h0;
      r3         <= 4'h0;
      OUT_SERIAL <= 4'h0;
      OUT_VALID  <= 1'b0;
      OUT_PARITY <= 1'b0;
      OUT_LAST   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      r0         <= r0_n;
      r1         <= r1_n;
      r2         <= r2_n;
      r3         <= r3_n;
      OUT_SERIAL <= out_serial_n;
      OUT_VALID  <= out_valid_n;
      OUT_PARITY <= out_parity_n;
      OUT_LAST   <= out_last_n;
    end
  end

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Bench for rs_encoder_15_11: directed frames plus random frames whose
// codewords are checked through the four syndromes at a^1..a^4.
module tb_rs_encoder_15_11;

  logic       CLK;
  logic       RESET_GLOBAL;
  logic [3:0] IN_SERIAL;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] OUT_SERIAL;
  logic       OUT_VALID;
  logic       OUT_PARITY;
  logic       OUT_LAST;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed output symbols: {last, parity, symbol} plus the cycle they appeared.
  logic [5:0] got_q[$];
  int         got_t_q[$];

  logic [3:0] frame_d[11];
  logic [3:0] cw_sym[15];
  logic       cw_par[15];
  logic       cw_last[15];
  int         cw_t[15];
  bit         cw_timeout;

  rs_encoder_15_11 dut (
    .CLK          (CLK),
    .RESET_GLOBAL (RESET_GLOBAL),
    .IN_SERIAL    (IN_SERIAL),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .OUT_SERIAL   (OUT_SERIAL),
    .OUT_VALID    (OUT_VALID),
    .OUT_PARITY   (OUT_PARITY),
    .OUT_LAST     (OUT_LAST)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output monitor, sampled shortly after each rising edge
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (OUT_VALID === 1'b1) begin
      got_q.push_back({OUT_LAST, OUT_PARITY, OUT_SERIAL});
      got_t_q.push_back(cyc);
    end
  end

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Evaluate the collected codeword (first symbol = x^14) at a^j.
  function automatic logic [3:0] syndrome(input int j);
    logic [3:0] a;
    logic [3:0] s;
    a = 4'h1;
    for (int k = 0; k < j; k++) a = gf_mul(a, 4'h2);
    s = 4'h0;
    for (int i = 0; i < 15; i++) s = gf_mul(s, a) ^ cw_sym[i];
    return s;
  endfunction

  // Driver: present frame_d[0..n-1]; junk 0xE is offered while not ready.
  task automatic drive_frame(input int n, input bit gaps, input bit hold);
    int  i;
    int  budget;
    bit  phase;
    i = 0; budget = 0; phase = 1'b0;
    while (i < n && budget < 200) begin
      @(negedge CLK);
      budget++;
      if (gaps && phase) begin
        IN_VALID  = 1'b0;
        IN_SERIAL = 4'h0;
      end else if (!IN_READY) begin
        IN_VALID  = 1'b1;
        IN_SERIAL = 4'hE;
      end else begin
        IN_VALID  = 1'b1;
        IN_SERIAL = frame_d[i];
        i++;
      end
      phase = ~phase;
    end
    if (!hold) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
  endtask

  // Pull one 15-symbol codeword from the monitor queue, bounded wait.
  task automatic collect_frame();
    int k;
    k = 0;
    while (got_q.size() < 15 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    cw_timeout = (got_q.size() < 15);
    for (int i = 0; i < 15; i++) begin
      if (got_q.size() > 0) begin
        {cw_last[i], cw_par[i], cw_sym[i]} = got_q.pop_front();
        cw_t[i] = got_t_q.pop_front();
      end else begin
        cw_sym[i] = 4'hx; cw_par[i] = 1'bx; cw_last[i] = 1'bx; cw_t[i] = -1;
      end
    end
  endtask

  task automatic test_reset();
    RESET_GLOBAL = 1'b1;
    IN_VALID     = 1'b1;
    IN_SERIAL    = 4'h5;
    repeat (3) @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_PARITY, OUT_LAST, OUT_SERIAL} !== 7'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {OUT_VALID, OUT_PARITY, OUT_LAST, OUT_SERIAL});
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", IN_READY);
    end
    RESET_GLOBAL = 1'b0;
    IN_VALID     = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_priority: got %0d outputs expected 0", got_q.size());
    end
    got_q.delete(); got_t_q.delete();
  endtask

  task automatic test_zero_frame();
    int low;
    for (int i = 0; i < 11; i++) frame_d[i] = 4'h0;
    drive_frame(11, 1'b0, 1'b0);
    low = 0;
    for (int i = 0; i < 8; i++) begin
      if (IN_READY !== 1'b1) low++;
      @(negedge CLK);
    end
    checks++;
    if (low != 4) begin
      errors++;
      $display("FAIL zero_ready_low: got %0d cycles expected 4", low);
    end
    collect_frame();
    checks++;
    if (cw_timeout) begin
      errors++;
      $display("FAIL zero_timeout: got fewer than 15 symbols expected 15");
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({cw_last[i], cw_par[i], cw_sym[i]} !== {(i == 14), (i >= 11), 4'h0}) begin
        errors++;
        $display("FAIL zero_sym%0d: got %b expected %b", i, {cw_last[i], cw_par[i], cw_sym[i]},
                 {(i == 14), (i >= 11), 4'h0});
      end
    end
  endtask

  task automatic test_single_one();
    logic [3:0] exp_par[4];
    exp_par[0] = 4'hD; exp_par[1] = 4'hC; exp_par[2] = 4'h8; exp_par[3] = 4'h7;
    for (int i = 0; i < 11; i++) frame_d[i] = (i == 10) ? 4'h1 : 4'h0;
    drive_frame(11, 1'b0, 1'b0);
    collect_frame();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({cw_par[i], cw_sym[i]} !== {1'b0, frame_d[i]}) begin
        errors++;
        $display("FAIL one_data%0d: got %h expected %h", i, cw_sym[i], frame_d[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cw_par[11+i], cw_sym[11+i]} !== {1'b1, exp_par[i]}) begin
        errors++;
        $display("FAIL one_parity%0d: got %h expected %h", i, cw_sym[11+i], exp_par[i]);
      end
    end
  endtask

  task automatic test_random(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 11; i++) frame_d[i] = 4'($urandom_range(0, 15));
      drive_frame(11, 1'b0, 1'b0);
      collect_frame();
      for (int i = 0; i < 15; i++) begin
        checks++;
        if ({cw_last[i], cw_par[i]} !== {(i == 14), (i >= 11)} ||
            (i < 11 && cw_sym[i] !== frame_d[i])) begin
          errors++;
          $display("FAIL rand_f%0d_sym%0d: got %b_%h expected flags %b%b data %h", f, i,
                   {cw_last[i], cw_par[i]}, cw_sym[i], (i == 14), (i >= 11), frame_d[i]);
        end
      end
      for (int j = 1; j <= 4; j++) begin
        checks++;
        if (syndrome(j) !== 4'h0) begin
          errors++;
          $display("FAIL rand_f%0d_S%0d: got %h expected 0", f, j, syndrome(j));
        end
      end
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 11; i++) frame_d[i] = 4'(i + 1);
    drive_frame(11, 1'b1, 1'b0);
    collect_frame();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cw_sym[i] !== frame_d[i]) begin
        errors++;
        $display("FAIL gap_data%0d: got %h expected %h", i, cw_sym[i], frame_d[i]);
      end
    end
    for (int i = 1; i < 15; i++) begin
      checks++;
      if (cw_t[i] - cw_t[i-1] != ((i <= 10) ? 2 : 1)) begin
        errors++;
        $display("FAIL gap_spacing%0d: got %0d expected %0d", i, cw_t[i] - cw_t[i-1], (i <= 10) ? 2 : 1);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (syndrome(j) !== 4'h0) begin
        errors++;
        $display("FAIL gap_S%0d: got %h expected 0", j, syndrome(j));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    // Abort in DATA after d5
    for (int i = 0; i < 11; i++) frame_d[i] = 4'(15 - i);
    drive_frame(6, 1'b0, 1'b0);
    RESET_GLOBAL = 1'b1;
    @(negedge CLK);
    RESET_GLOBAL = 1'b0;
    repeat (6) @(negedge CLK);
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL abort_data_count: got %0d expected 6", got_q.size());
    end
    got_q.delete(); got_t_q.delete();
    // Abort in PARITY right after d10 is accepted
    drive_frame(11, 1'b0, 1'b0);
    RESET_GLOBAL = 1'b1;
    @(negedge CLK);
    RESET_GLOBAL = 1'b0;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL abort_parity_ready: got %b expected 1", IN_READY);
    end
    repeat (6) @(negedge CLK);
    checks++;
    if (got_q.size() != 11) begin
      errors++;
      $display("FAIL abort_parity_count: got %0d expected 11", got_q.size());
    end
    got_q.delete(); got_t_q.delete();
    // Fresh frame after abort
    for (int i = 0; i < 11; i++) frame_d[i] = 4'((i * 7 + 3) % 16);
    drive_frame(11, 1'b0, 1'b0);
    collect_frame();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cw_par[i] !== (i >= 11) || (i < 11 && cw_sym[i] !== frame_d[i])) begin
        errors++;
        $display("FAIL abort_new_sym%0d: got %b_%h expected %b_%h", i, cw_par[i], cw_sym[i], (i >= 11), frame_d[i]);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (syndrome(j) !== 4'h0) begin
        errors++;
        $display("FAIL abort_new_S%0d: got %h expected 0", j, syndrome(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] frame_b[11];
    int         t_last_a;
    for (int i = 0; i < 11; i++) frame_d[i] = 4'((i * 5 + 1) % 16);
    for (int i = 0; i < 11; i++) frame_b[i] = 4'((i * 3 + 9) % 16);
    drive_frame(11, 1'b0, 1'b1);
    frame_d = frame_b;
    drive_frame(11, 1'b0, 1'b0);
    // frame A
    collect_frame();
    t_last_a = cw_t[14];
    checks++;
    if (cw_last[14] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a_last: got %b expected 1", cw_last[14]);
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (syndrome(j) !== 4'h0) begin
        errors++;
        $display("FAIL b2b_a_S%0d: got %h expected 0", j, syndrome(j));
      end
    end
    // frame B: junk offered during A's parity must not be consumed
    collect_frame();
    checks++;
    if (cw_t[0] != t_last_a + 1) begin
      errors++;
      $display("FAIL b2b_gapless: got cycle %0d expected %0d", cw_t[0], t_last_a + 1);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({cw_par[i], cw_sym[i]} !== {1'b0, frame_b[i]}) begin
        errors++;
        $display("FAIL b2b_b_data%0d: got %h expected %h", i, cw_sym[i], frame_b[i]);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (syndrome(j) !== 4'h0) begin
        errors++;
        $display("FAIL b2b_b_S%0d: got %h expected 0", j, syndrome(j));
      end
    end
  endtask

  initial begin
    RESET_GLOBAL = 1'b1;
    IN_VALID     = 1'b0;
    IN_SERIAL    = 4'h0;
    test_reset();
    test_zero_frame();
    test_single_one();
    test_random(1000);
    test_gaps();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (5) @(negedge CLK);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL trailing_outputs: got %0d expected 0", got_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
